demux_tree: RTL and testbench

//   Buffered 1-to-4 demultiplexer, the distribution end of the 4:1 priority mux tree.
//   - One input word is routed to one of four output lanes, using the same s1/s2/s3

---
 rtl/demux_tree.sv | 154 +++++++++++++++
 tb/tb_demux_tree.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_tree.sv
// rtl/demux_tree.sv - buffered 1-to-4 demultiplexer with per-lane valid/ready output registers
//
// Routes one upstream word into one of four single-entry output lanes. The lane
// is chosen by priority decode of the selects: s3 wins over s2, s2 wins over s1,
// and no select chooses lane 0. A full lane that is not being drained
// back-pressures only the words that are aimed at it.
//
// Optional feature macro: DEMUX_TREE_STATS_EN (adds saturating per-lane accept counters)
//
// Ports:
//   clock                 in   rising-edge clock
//   reset                 in   asynchronous active-high reset
//   io_in_valid           in   upstream word valid
//   io_in_ready           out  word can be accepted into the selected lane this cycle
//   io_in_bits            in   upstream data word [DATA_W]
//   io_s1/io_s2/io_s3     in   lane selects, s3 highest priority
//   io_out_N_valid        out  lane N holds a word (N = 0..3)
//   io_out_N_ready        in   downstream lane N accepts the word
//   io_out_N_bits         out  lane N data word [DATA_W]
//   io_cnt_N              out  lane N accepted-transfer count [CNT_W] (DEMUX_TREE_STATS_EN only)

module demux_tree #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_in_valid,
   output logic              io_in_ready,
   input  logic [DATA_W-1:0] io_in_bits,
   input  logic              io_s1,
   input  logic              io_s2,
   input  logic              io_s3,
   output logic              io_out_0_valid,
   input  logic              io_out_0_ready,
   output logic [DATA_W-1:0] io_out_0_bits,
   output logic              io_out_1_valid,
   input  logic              io_out_1_ready,
   output logic [DATA_W-1:0] io_out_1_bits,
   output logic              io_out_2_valid,
   input  logic              io_out_2_ready,
   output logic [DATA_W-1:0] io_out_2_bits,
   output logic              io_out_3_valid,
   input  logic              io_out_3_ready,
   output logic [DATA_W-1:0] io_out_3_bits
`ifdef DEMUX_TREE_STATS_EN
   ,
   output logic [CNT_W-1:0]  io_cnt_0,
   output logic [CNT_W-1:0]  io_cnt_1,
   output logic [CNT_W-1:0]  io_cnt_2,
   output logic [CNT_W-1:0]  io_cnt_3
`endif
);

   logic [1:0]        sel;
   logic [3:0]        out_ready;
   logic              accept;

   logic [3:0]        valid_q;
   logic [3:0]        valid_d;
   logic [DATA_W-1:0] bits_q [4];
   logic [DATA_W-1:0] bits_d [4];

   // Same priority encoding as the matching 4:1 mux tree.
   always_comb begin
      sel = 2'd0;
      if (io_s3) begin
         sel = 2'd3;
      end else if (io_s2) begin
         sel = 2'd2;
      end else if (io_s1) begin
         sel = 2'd1;
      end
   end

   assign out_ready = {io_out_3_ready, io_out_2_ready, io_out_1_ready, io_out_0_ready};

   // Ready depends only on lane state, selects and downstream ready, never on
   // io_in_valid, so upstream may wait for ready before raising valid.
   assign io_in_ready = !valid_q[sel] || out_ready[sel];
   assign accept      = io_in_valid && io_in_ready;

   // Per-lane EMPTY/FULL tracking. A drain clears the lane, but an accept on the
   // same edge refills it, which gives one word per cycle per lane.
   always_comb begin
      valid_d = valid_q;
      for (int i = 0; i < 4; i++) begin
         bits_d[i] = bits_q[i];
         if (valid_q[i] && out_ready[i]) begin
            valid_d[i] = 1'b0;
         end
         if (accept && (sel == 2'(i))) begin
            valid_d[i] = 1'b1;
            bits_d[i]  = io_in_bits;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q <= 4'b0000;
         for (int i = 0; i < 4; i++) begin
            bits_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         for (int i = 0; i < 4; i++) begin
            bits_q[i] <= bits_d[i];
         end
      end
   end

   assign io_out_0_valid = valid_q[0];
   assign io_out_1_valid = valid_q[1];
   assign io_out_2_valid = valid_q[2];
   assign io_out_3_valid = valid_q[3];
   assign io_out_0_bits  = bits_q[0];
   assign io_out_1_bits  = bits_q[1];
   assign io_out_2_bits  = bits_q[2];
   assign io_out_3_bits  = bits_q[3];

`ifdef DEMUX_TREE_STATS_EN
   logic [CNT_W-1:0] cnt_q [4];
   logic [CNT_W-1:0] cnt_d [4];

   // Counters stick at all-ones rather than wrapping.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = cnt_q[i];
         if (accept && (sel == 2'(i)) && (cnt_q[i] != {CNT_W{1'b1}})) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign io_cnt_0 = cnt_q[0];
   assign io_cnt_1 = cnt_q[1];
   assign io_cnt_2 = cnt_q[2];
   assign io_cnt_3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux_tree.sv
// tb/tb_demux_tree.sv - self-checking bench for demux_tree

module tb_demux_tree;

   localparam int DATA_W = 8;
   localparam int CNT_W  = 4;

   logic              clock = 1'b0;
   logic              reset;
   logic              io_in_valid;
   logic              io_in_ready;
   logic [DATA_W-1:0] io_in_bits;
   logic              io_s1, io_s2, io_s3;
   logic              io_out_0_valid, io_out_1_valid, io_out_2_valid, io_out_3_valid;
   logic              io_out_0_ready, io_out_1_ready, io_out_2_ready, io_out_3_ready;
   logic [DATA_W-1:0] io_out_0_bits, io_out_1_bits, io_out_2_bits, io_out_3_bits;
`ifdef DEMUX_TREE_STATS_EN
   logic [CNT_W-1:0]  io_cnt_0, io_cnt_1, io_cnt_2, io_cnt_3;
`endif

   demux_tree #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset),
      .io_in_valid(io_in_valid), .io_in_ready(io_in_ready), .io_in_bits(io_in_bits),
      .io_s1(io_s1), .io_s2(io_s2), .io_s3(io_s3),
      .io_out_0_valid(io_out_0_valid), .io_out_0_ready(io_out_0_ready), .io_out_0_bits(io_out_0_bits),
      .io_out_1_valid(io_out_1_valid), .io_out_1_ready(io_out_1_ready), .io_out_1_bits(io_out_1_bits),
      .io_out_2_valid(io_out_2_valid), .io_out_2_ready(io_out_2_ready), .io_out_2_bits(io_out_2_bits),
      .io_out_3_valid(io_out_3_valid), .io_out_3_ready(io_out_3_ready), .io_out_3_bits(io_out_3_bits)
`ifdef DEMUX_TREE_STATS_EN
      ,
      .io_cnt_0(io_cnt_0), .io_cnt_1(io_cnt_1), .io_cnt_2(io_cnt_2), .io_cnt_3(io_cnt_3)
`endif
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   logic              dv [4];
   logic [DATA_W-1:0] db [4];
   logic              rdy [4];
   assign dv[0] = io_out_0_valid;  assign db[0] = io_out_0_bits;  assign rdy[0] = io_out_0_ready;
   assign dv[1] = io_out_1_valid;  assign db[1] = io_out_1_bits;  assign rdy[1] = io_out_1_ready;
   assign dv[2] = io_out_2_valid;  assign db[2] = io_out_2_bits;  assign rdy[2] = io_out_2_ready;
   assign dv[3] = io_out_3_valid;  assign db[3] = io_out_3_bits;  assign rdy[3] = io_out_3_ready;

   // Reference model: each lane is a one-word slot that is emptied when the
   // downstream takes it and filled when upstream hands it a word.
   bit          m_full [4];
   int          m_word [4];
   int          m_cnt  [4];

   function automatic int lane_of(input logic s1, input logic s2, input logic s3);
      if (s3) return 3;
      if (s2) return 2;
      if (s1) return 1;
      return 0;
   endfunction

   function automatic bit model_ready();
      int l;
      l = lane_of(io_s1, io_s2, io_s3);
      return !m_full[l] || (rdy[l] === 1'b1);
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            m_full[i] = 1'b0;
            m_word[i] = 0;
            m_cnt[i]  = 0;
         end
      end else begin
         int  tgt;
         bit  take;
         tgt  = lane_of(io_s1, io_s2, io_s3);
         take = io_in_valid && model_ready();
         for (int i = 0; i < 4; i++) begin
            if (m_full[i] && rdy[i]) m_full[i] = 1'b0;
         end
         if (take) begin
            m_full[tgt] = 1'b1;
            m_word[tgt] = int'(io_in_bits);
            if (m_cnt[tgt] < (1 << CNT_W) - 1) m_cnt[tgt]++;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clock) begin
      if (!reset) begin
         check("in_ready", 32'(io_in_ready), 32'(model_ready()));
         for (int i = 0; i < 4; i++) begin
            check($sformatf("lane%0d_valid", i), 32'(dv[i]), 32'(m_full[i]));
            check($sformatf("lane%0d_bits", i), 32'(db[i]), 32'(m_word[i]));
         end
`ifdef DEMUX_TREE_STATS_EN
         check("cnt0", 32'(io_cnt_0), 32'(m_cnt[0]));
         check("cnt1", 32'(io_cnt_1), 32'(m_cnt[1]));
         check("cnt2", 32'(io_cnt_2), 32'(m_cnt[2]));
         check("cnt3", 32'(io_cnt_3), 32'(m_cnt[3]));
`endif
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic s3, input logic s2, input logic s1,
                        input logic [DATA_W-1:0] b);
      io_in_valid = v; io_s3 = s3; io_s2 = s2; io_s1 = s1; io_in_bits = b;
   endtask

   task automatic set_ready(input logic [3:0] r);
      io_out_0_ready = r[0]; io_out_1_ready = r[1];
      io_out_2_ready = r[2]; io_out_3_ready = r[3];
   endtask

   // Directed vectors: {valid, s3, s2, s1, bits, ready[3:0]}
   typedef struct packed {
      logic       v;
      logic [2:0] s;
      logic [7:0] b;
      logic [3:0] r;
   } vec_t;

   vec_t vecs [12];

   initial begin
      vecs[0]  = '{1'b1, 3'b000, 8'h10, 4'b0000};
      vecs[1]  = '{1'b1, 3'b000, 8'h11, 4'b0000};
      vecs[2]  = '{1'b1, 3'b001, 8'h12, 4'b0000};
      vecs[3]  = '{1'b1, 3'b101, 8'h13, 4'b0000};
      vecs[4]  = '{1'b1, 3'b011, 8'h14, 4'b0001};
      vecs[5]  = '{1'b1, 3'b000, 8'h15, 4'b0001};
      vecs[6]  = '{1'b1, 3'b111, 8'h16, 4'b1000};
      vecs[7]  = '{1'b0, 3'b001, 8'h17, 4'b0010};
      vecs[8]  = '{1'b1, 3'b001, 8'h18, 4'b0110};
      vecs[9]  = '{1'b1, 3'b010, 8'h19, 4'b1111};
      vecs[10] = '{1'b1, 3'b100, 8'h1A, 4'b0000};
      vecs[11] = '{1'b0, 3'b000, 8'h00, 4'b1111};

      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      set_ready(4'b0000);
      tick(); tick();
      reset = 1'b0;
      #1;

      // 1. idle after reset
      check("idle_ready", 32'(io_in_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("idle_valid%0d", i), 32'(dv[i]), 32'd0);
         check($sformatf("idle_bits%0d", i), 32'(db[i]), 32'd0);
      end

      // 2. priority decode: s1=s2=1 -> lane 2
      drive(1'b1, 1'b0, 1'b1, 1'b1, 8'hA5);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      check("dec_valid2", 32'(io_out_2_valid), 32'd1);
      check("dec_bits2", 32'(io_out_2_bits), 32'hA5);
      check("dec_valid0", 32'(io_out_0_valid), 32'd0);
      check("dec_valid1", 32'(io_out_1_valid), 32'd0);
      check("dec_valid3", 32'(io_out_3_valid), 32'd0);
      set_ready(4'b0100);
      tick();
      set_ready(4'b0000);
      check("drain_valid2", 32'(io_out_2_valid), 32'd0);
      check("drain_bits2_held", 32'(io_out_2_bits), 32'hA5);

      // 3. back-pressure on lane 0, then retarget to lane 3
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h22);
      #1;
      check("bp_ready", 32'(io_in_ready), 32'd0);
      tick();
      check("bp_hold_valid0", 32'(io_out_0_valid), 32'd1);
      check("bp_hold_bits0", 32'(io_out_0_bits), 32'h11);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h22);
      #1;
      check("retarget_ready", 32'(io_in_ready), 32'd1);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      check("retarget_valid3", 32'(io_out_3_valid), 32'd1);
      check("retarget_bits3", 32'(io_out_3_bits), 32'h22);
      check("retarget_bits0", 32'(io_out_0_bits), 32'h11);

      // 5. asynchronous reset while lanes 0 and 3 are full
      #2;
      reset = 1'b1;
      #1;
      check("arst_valid0", 32'(io_out_0_valid), 32'd0);
      check("arst_valid3", 32'(io_out_3_valid), 32'd0);
      check("arst_bits0", 32'(io_out_0_bits), 32'd0);
      check("arst_bits3", 32'(io_out_3_bits), 32'd0);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h77);
      tick();
      check("arst_no_accept", 32'(io_out_1_valid), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      reset = 1'b0;
      tick();
      check("post_rst_ready", 32'(io_in_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("post_rst_valid%0d", i), 32'(dv[i]), 32'd0);
      end

      // 4. streaming 0x01..0x08 into lane 1 with ready held
      set_ready(4'b0010);
      for (int k = 1; k <= 8; k++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b1, 8'(k));
         #1;
         check("stream_ready", 32'(io_in_ready), 32'd1);
         tick();
         check("stream_valid1", 32'(io_out_1_valid), 32'd1);
         check("stream_bits1", 32'(io_out_1_bits), 32'(k));
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      tick();
      check("stream_end_valid1", 32'(io_out_1_valid), 32'd0);
      set_ready(4'b0000);

      // directed mix checked by the model
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].v, vecs[i].s[2], vecs[i].s[1], vecs[i].s[0], vecs[i].b);
         set_ready(vecs[i].r);
         tick();
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      set_ready(4'b0000);
      tick();

`ifdef DEMUX_TREE_STATS_EN
      // 6. counter saturation on lane 2
      reset = 1'b1;
      tick();
      reset = 1'b0;
      set_ready(4'b0100);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h5A);
      for (int k = 0; k < 20; k++) tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      tick();
      check("sat_cnt2", 32'(io_cnt_2), 32'd15);
      check("sat_cnt0", 32'(io_cnt_0), 32'd0);
      check("sat_cnt1", 32'(io_cnt_1), 32'd0);
      check("sat_cnt3", 32'(io_cnt_3), 32'd0);
`endif

      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
